reg_dump_streamer: RTL and testbench

- Hardware replacement for periodic register-file dumps.
- Snoops the CPU register-file write port into a shadow array.
- On a periodic interval or a manual trigger, takes an atomic snapshot and streams it out as REGS_PER_BEAT registers per beat over a valid/ready interface.
- Sits beside the CPU register file; its output feeds a trace FIFO or a UART bridge.

---
 rtl/reg_dump_streamer.sv | 126 ++++++++++++
 tb/tb_reg_dump_streamer.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_dump_streamer.sv
// reg_dump_streamer: shadows register-file writes and streams atomic snapshots over valid/ready.
// Define REG_DUMP_DIRTY_EN to send only beats holding registers written since the previous dump.
module reg_dump_streamer #(
  parameter int DATA_W        = 32,
  parameter int NUM_REGS      = 32,
  parameter int ADDR_W        = 5,
  parameter int REGS_PER_BEAT = 2,
  parameter int INTERVAL      = 5,
  parameter int CNT_W         = 16
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            wr_en,
  input  logic [ADDR_W-1:0]               wr_addr,
  input  logic [DATA_W-1:0]               wr_data,
  input  logic                            trigger,
  output logic                            dump_valid,
  input  logic                            dump_ready,
  output logic [ADDR_W-1:0]               dump_idx,
  output logic [REGS_PER_BEAT*DATA_W-1:0] dump_data,
  output logic                            dump_last,
  output logic                            busy,
  output logic [CNT_W-1:0]                dropped
);
  localparam int NB = NUM_REGS / REGS_PER_BEAT;
  localparam int PW = NB > 1 ? $clog2(NB) : 1;
  localparam int CW = INTERVAL > 1 ? $clog2(INTERVAL) : 1;
  typedef enum logic {IDLE, SEND} state_t;
  state_t            state_q;
  logic [DATA_W-1:0] shadow_q [NUM_REGS];
  logic [DATA_W-1:0] shadow_d [NUM_REGS];
  logic [DATA_W-1:0] snap_q [NUM_REGS];
  logic [PW-1:0]     ptr_q, first_p, next_p;
  logic [CW-1:0]     cnt_q;
  logic [CNT_W-1:0]  dropped_q;
  logic              valid_q, wr_ok, expire, req, first_v, next_v;
  logic [NB-1:0]     start_mask, mask;
  assign wr_ok  = wr_en && wr_addr != '0 && int'(wr_addr) < NUM_REGS;
  assign expire = INTERVAL != 0 && cnt_q == CW'(INTERVAL - 1);
  assign req    = trigger || expire;
`ifdef REG_DUMP_DIRTY_EN
  logic [NUM_REGS-1:0] dirty_q;
  logic [NB-1:0]       mask_q;
  logic                start;
  assign start = state_q == IDLE && req;
  assign mask  = mask_q;
  always_comb begin
    start_mask = '0;
    for (int b = 0; b < NB; b++)
      for (int r = 0; r < REGS_PER_BEAT; r++)
        start_mask[b] = start_mask[b] | dirty_q[b*REGS_PER_BEAT + r];
  end
  // a write coinciding with dump start is not in this dump's dirty set, so it survives the clear
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      dirty_q <= '0;
      mask_q  <= '0;
    end else begin
      if (start) mask_q <= start_mask;
      for (int i = 0; i < NUM_REGS; i++)
        dirty_q[i] <= (dirty_q[i] && !start) || (wr_ok && int'(wr_addr) == i);
    end
`else
  assign start_mask = '1;
  assign mask       = '1;
`endif
  always_comb
    for (int i = 0; i < NUM_REGS; i++)
      shadow_d[i] = (wr_ok && int'(wr_addr) == i) ? wr_data : shadow_q[i];
  always_comb begin
    first_v = 1'b0;
    first_p = '0;
    next_v  = 1'b0;
    next_p  = '0;
    for (int b = NB - 1; b >= 0; b--) begin
      if (start_mask[b]) begin
        first_v = 1'b1;
        first_p = PW'(b);
      end
      if (mask[b] && b > int'(ptr_q)) begin
        next_v = 1'b1;
        next_p = PW'(b);
      end
    end
  end
  always_comb begin
    dump_data = '0;
    if (valid_q)
      for (int r = 0; r < REGS_PER_BEAT; r++)
        dump_data[r*DATA_W +: DATA_W] = snap_q[int'(ptr_q)*REGS_PER_BEAT + r];
  end
  assign dump_valid = valid_q;
  assign dump_idx   = valid_q ? ADDR_W'(int'(ptr_q) * REGS_PER_BEAT) : '0;
  assign dump_last  = valid_q && !next_v;
  assign busy       = state_q == SEND;
  assign dropped    = dropped_q;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q   <= IDLE;
      valid_q   <= 1'b0;
      ptr_q     <= '0;
      cnt_q     <= '0;
      dropped_q <= '0;
      for (int i = 0; i < NUM_REGS; i++) begin
        shadow_q[i] <= '0;
        snap_q[i]   <= '0;
      end
    end else begin
      cnt_q <= (expire || INTERVAL == 0) ? '0 : cnt_q + 1'b1;
      if (wr_ok) shadow_q[wr_addr] <= wr_data;
      if (state_q == SEND && req && dropped_q != '1) dropped_q <= dropped_q + 1'b1;
      case (state_q)
        IDLE: if (req) begin
          state_q <= SEND;
          snap_q  <= shadow_d;
          ptr_q   <= first_p;
          valid_q <= first_v;
        end
        SEND: if (!valid_q || (dump_ready && !next_v)) begin
          state_q <= IDLE;
          valid_q <= 1'b0;
        end else if (dump_ready) ptr_q <= next_p;
        default: state_q <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_reg_dump_streamer.sv
// tb_reg_dump_streamer: two instances (manual-only and interval 5 with 4-bit drop counter)
// compared every cycle against a queue-of-beats reference model, plus directed corner cases.
module tb_reg_dump_streamer;
  logic clk = 0, reset = 0, wr_en = 0, trigger = 0, ready = 1;
  logic [4:0]  wr_addr = 0;
  logic [31:0] wr_data = 0;
  logic        v [2], l [2], b [2];
  logic [4:0]  ix [2];
  logic [63:0] dt [2];
  logic [15:0] dr0;
  logic [3:0]  dr1;
  always #5 clk = ~clk;

  reg_dump_streamer #(.INTERVAL(0)) d0 (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .trigger(trigger), .dump_valid(v[0]), .dump_ready(ready), .dump_idx(ix[0]),
    .dump_data(dt[0]), .dump_last(l[0]), .busy(b[0]), .dropped(dr0));
  reg_dump_streamer #(.INTERVAL(5), .CNT_W(4)) d1 (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .trigger(trigger), .dump_valid(v[1]), .dump_ready(ready), .dump_idx(ix[1]),
    .dump_data(dt[1]), .dump_last(l[1]), .busy(b[1]), .dropped(dr1));

  typedef struct packed {logic [4:0] idx; logic [63:0] data; logic last;} beat_t;
  typedef struct {logic [4:0] idx; logic [63:0] data; logic last; int cyc;} cap_t;
  typedef struct {logic [4:0] wa; logic [31:0] wd; logic [4:0] ei; logic [63:0] ed;} vec_t;

  logic [31:0] sh [32];
  logic [31:0] mdirty [2];
  beat_t       mq [2][$];
  int          mdrop [2];
  logic        pulse [2];
  int          mcyc, tcyc, pass_n, tot_n;
  cap_t        cap [$];
  vec_t        tbl [5];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tot_n++;
    if (act === exp) pass_n++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, tcyc);
  endtask

  task automatic model_clear();
    foreach (sh[i]) sh[i] = '0;
    for (int k = 0; k < 2; k++) begin
      mq[k].delete();
      mdrop[k]  = 0;
      pulse[k]  = 0;
      mdirty[k] = '0;
    end
    mcyc = 0;
  endtask

  function automatic logic keep(input int k, input int bb);
`ifdef REG_DUMP_DIRTY_EN
    return mdirty[k][2*bb] | mdirty[k][2*bb+1];
`else
    return 1'b1;
`endif
  endfunction

  // one clock edge: write lands first so a starting dump sees it; dirty bits update afterwards
  task automatic model_step();
    beat_t nb;
    logic  req;
    int    hi;
    if (reset) begin
      model_clear();
      return;
    end
    if (wr_en && wr_addr != 0) sh[wr_addr] = wr_data;
    for (int k = 0; k < 2; k++) begin
      req = trigger || (k == 1 && mcyc % 5 == 4);
      if (mq[k].size() > 0 || pulse[k]) begin
        if (req && mdrop[k] < (k == 1 ? 15 : 65535)) mdrop[k]++;
        pulse[k] = 0;
        if (mq[k].size() > 0 && ready) void'(mq[k].pop_front());
      end else if (req) begin
        hi = -1;
        for (int bb = 0; bb < 16; bb++) if (keep(k, bb)) hi = bb;
        for (int bb = 0; bb <= hi; bb++)
          if (keep(k, bb)) begin
            nb.idx  = 5'(2 * bb);
            nb.data = {sh[2*bb+1], sh[2*bb]};
            nb.last = bb == hi;
            mq[k].push_back(nb);
          end
        pulse[k]  = hi < 0;
        mdirty[k] = '0;
      end
      if (wr_en && wr_addr != 0) mdirty[k][wr_addr] = 1'b1;
    end
    mcyc++;
  endtask

  task automatic cycle();
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("valid%0d", k), 64'(v[k]), 64'(mq[k].size() > 0));
      chk($sformatf("busy%0d", k), 64'(b[k]), 64'(mq[k].size() > 0 || pulse[k]));
      chk($sformatf("dropped%0d", k), k == 1 ? 64'(dr1) : 64'(dr0), 64'(mdrop[k]));
      if (mq[k].size() > 0) begin
        chk($sformatf("idx%0d", k), 64'(ix[k]), 64'(mq[k][0].idx));
        chk($sformatf("data%0d", k), dt[k], mq[k][0].data);
        chk($sformatf("last%0d", k), 64'(l[k]), 64'(mq[k][0].last));
      end
    end
    if (v[0] && ready) cap.push_back('{ix[0], dt[0], l[0], tcyc});
    model_step();
    tcyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic write(input logic [4:0] a, input logic [31:0] d);
    wr_en = 1; wr_addr = a; wr_data = d;
    cycle();
    wr_en = 0;
  endtask

  task automatic find(input logic [4:0] i, output logic f, output logic [63:0] d);
    f = 0;
    d = '0;
    foreach (cap[j]) if (cap[j].idx == i) begin f = 1; d = cap[j].data; end
  endtask

  task automatic dump(input int n);
    cap.delete();
    trigger = 1;
    cycle();
    trigger = 0;
    repeat (n) cycle();
  endtask

  initial begin
    logic        f;
    logic [63:0] d;
    int          t0, base, nz;
    tbl[0] = '{5'd1,  32'h11111111, 5'd0,  64'h11111111_00000000};
    tbl[1] = '{5'd2,  32'h22222222, 5'd2,  64'h00000000_22222222};
    tbl[2] = '{5'd0,  32'hFFFFFFFF, 5'd0,  64'h11111111_00000000};
    tbl[3] = '{5'd31, 32'hDEADBEEF, 5'd30, 64'hDEADBEEF_00000000};
    tbl[4] = '{5'd16, 32'h12345678, 5'd16, 64'h00000000_12345678};
    #1 reset = 1;
    #1;
    chk("rst_valid", 64'(v[0]), 0);
    chk("rst_busy", 64'(b[0]), 0);
    chk("rst_last", 64'(l[0]), 0);
    chk("rst_idx", 64'(ix[0]), 0);
    chk("rst_data", dt[0], 0);
    chk("rst_dropped", 64'(dr1), 0);
    model_clear();
    repeat (2) cycle();
    reset = 0;

    for (int i = 0; i < 5; i++) write(tbl[i].wa, tbl[i].wd);
    t0 = tcyc;
    dump(20);
`ifndef REG_DUMP_DIRTY_EN
    chk("full_count", 64'(cap.size()), 16);
    foreach (cap[i]) begin
      chk("full_idx", 64'(cap[i].idx), 64'(2 * i));
      chk("full_cyc", 64'(cap[i].cyc), 64'(t0 + 1 + i));
      chk("full_last", 64'(cap[i].last), 64'(i == 15));
    end
`endif
    for (int i = 0; i < 5; i++) begin
      find(tbl[i].ei, f, d);
      chk("tbl_found", 64'(f), 1);
      chk("tbl_data", d, tbl[i].ed);
    end

    cap.delete();
    trigger = 1;
    cycle();
    trigger = 0;
    for (int i = 0; i < 40; i++) begin
      ready = (i % 4 == 0 || i % 4 == 3);
      cycle();
    end
    ready = 1;
`ifndef REG_DUMP_DIRTY_EN
    chk("stall_count", 64'(cap.size()), 16);
`endif
    foreach (cap[i]) chk("stall_idx", 64'(cap[i].idx), 64'(2 * i));

`ifndef REG_DUMP_DIRTY_EN
    base = int'(dr0);
    cap.delete();
    trigger = 1;
    cycle();
    for (int i = 0; i < 3; i++) begin
      trigger = 0;
      cycle();
      trigger = 1;
      cycle();
    end
    trigger = 0;
    repeat (20) cycle();
    chk("drop3", 64'(dr0), 64'(base + 3));
    chk("drop_count", 64'(cap.size()), 16);
`endif

    cap.delete();
    trigger = 1; wr_en = 1; wr_addr = 5; wr_data = 32'hAAAA5555;
    cycle();
    trigger = 0;
    write(5'd5, 32'h0000BEEF);
    repeat (20) cycle();
`ifndef REG_DUMP_DIRTY_EN
    find(5'd4, f, d);
    chk("r5_old", d[63:32], 32'hAAAA5555);
`endif
    dump(20);
    find(5'd4, f, d);
    chk("r5_new", d[63:32], 32'h0000BEEF);

    dump(7);
`ifndef REG_DUMP_DIRTY_EN
    chk("beat7_idx", 64'(ix[0]), 14);
`endif
    reset = 1;
    #1;
    model_clear();
    chk("abort_valid0", 64'(v[0]), 0);
    chk("abort_busy0", 64'(b[0]), 0);
    chk("abort_idx0", 64'(ix[0]), 0);
    chk("abort_data0", dt[0], 0);
    chk("abort_valid1", 64'(v[1]), 0);
    chk("abort_busy1", 64'(b[1]), 0);
    repeat (2) cycle();
    reset = 0;
    dump(20);
    nz = 0;
    foreach (cap[i]) if (cap[i].data != 0) nz++;
    chk("cleared_shadow", 64'(nz), 0);
`ifndef REG_DUMP_DIRTY_EN
    chk("cleared_count", 64'(cap.size()), 16);
`else
    write(5'd9, 32'h99999999);
    dump(6);
    chk("dirty_count", 64'(cap.size()), 1);
    if (cap.size() > 0) begin
      chk("dirty_idx", 64'(cap[0].idx), 8);
      chk("dirty_last", 64'(cap[0].last), 1);
    end
    dump(4);
    chk("dirty_empty", 64'(cap.size()), 0);
`endif

    for (int i = 0; i < 2000; i++) begin
      wr_en   = $urandom_range(0, 2) == 0;
      wr_addr = 5'($urandom_range(0, 31));
      wr_data = $urandom;
      trigger = $urandom_range(0, 22) == 0;
      ready   = $urandom_range(0, 3) != 0;
      cycle();
    end
    $display("%0d/%0d checks passed", pass_n, tot_n);
    $finish;
  end
endmodule
